// File: rtl/anim_pkg.sv
// Shared definitions for the animation frame sequencer.
// Provides:
// - the animation-id, frame and speed field widths;
// - the limit value that flags an unsupported animation;
// - the animation id constants;
// - a helper that recognises limits with nothing to step through.
package anim_pkg;

  localparam int ANIM_W  = 3;
  localparam int FRAME_W = 5;
  localparam int SPEED_W = 2;

  localparam logic [FRAME_W-1:0] LIMIT_UNSUPPORTED = 5'd31;

  typedef enum logic [ANIM_W-1:0] {
    ANI0 = 3'd0,
    ANI1 = 3'd1,
    ANI2 = 3'd2,
    ANI3 = 3'd3,
    ANI4 = 3'd4,
    ANI5 = 3'd5,
    ANI6 = 3'd6,
    ANI7 = 3'd7
  } anim_id_e;

  // A limit of 0 or 1 leaves only frame 0, so the sequencer parks there.
  function automatic logic limit_is_degenerate(input logic [FRAME_W-1:0] lim);
    return (lim <= 5'd1);
  endfunction

endpackage

// File: rtl/anim_tick_prescaler.sv
// Frame-rate prescaler.
// The counter runs from 0 to (BASE_DIV >> speed) - 1 while run is high.
// It returns to 0 after the terminal count and holds while run is low.
// BASE_DIV must be at least 8, a multiple of 8, and no more than 2^DIV_W.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_run      : count enable
//   i_speed    : period = BASE_DIV >> i_speed
//   i_clear    : synchronous restart from 0 (animation change)
//   o_tick     : high in the cycle the count sits at or past the terminal value
module anim_tick_prescaler
  import anim_pkg::*;
#(
  parameter int BASE_DIV = 10_000_000,
  parameter int DIV_W    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_clear,
  output logic               o_tick
);

  // One extra bit so that BASE_DIV == 2^DIV_W still fits.
  localparam logic [DIV_W:0] BASE_PERIOD = (DIV_W+1)'(BASE_DIV);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W:0]   w_terminal;
  logic             w_at_term;

  // Terminal compare uses >= so that a speed increase, which lowers the
  // terminal below the current count, ticks at once instead of wrapping.
  always_comb begin
    w_terminal = (BASE_PERIOD >> i_speed) - {{DIV_W{1'b0}}, 1'b1};
    w_at_term  = ({1'b0, r_count} >= w_terminal);
    o_tick     = i_run & w_at_term;
  end

  // Prescaler count register: clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {DIV_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {DIV_W{1'b0}};
    end else if (i_run) begin
      if (w_at_term) begin
        r_count <= {DIV_W{1'b0}};
      end else begin
        r_count <= r_count + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Animation frame sequencer.
// Produces the current frame index for the 7-segment pattern lookup.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_animation     : selected animation id
//   i_limit         : frame count of that animation (31 = unsupported)
//   i_speed         : frame period = BASE_DIV >> i_speed cycles
//   i_run           : 1 free-run, 0 paused
//   i_step          : one-cycle pulse, advances one frame while paused
//   o_frame         : registered frame index
//   o_frame_valid   : registered (limit != 31)
//   o_wrap          : one-cycle pulse when the frame returns to 0 by advancing
module anim_frame_sequencer
  import anim_pkg::*;
#(
  parameter int BASE_DIV = 10_000_000,
  parameter int DIV_W    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANIM_W-1:0]  i_animation,
  input  logic [FRAME_W-1:0] i_limit,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_run,
  input  logic               i_step,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_frame_valid,
  output logic               o_wrap
);

  logic [FRAME_W-1:0] r_frame;
  logic               r_frame_valid;
  logic               r_wrap;
  logic [ANIM_W-1:0]  r_anim_q;

  logic               w_tick;
  logic               w_anim_change;
  logic               w_advance;
  logic [FRAME_W-1:0] w_frame_next;
  logic               w_wrap_next;

  anim_tick_prescaler #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_run   (i_run),
    .i_speed (i_speed),
    .i_clear (w_anim_change),
    .o_tick  (w_tick)
  );

  // Next frame and wrap, in priority order:
  // animation change, unsupported, degenerate, wrap, increment, hold.
  // The >= compare also catches a limit that shrank below a stale frame.
  always_comb begin
    w_anim_change = (i_animation != r_anim_q);
    // Step is only honoured while paused.
    w_advance     = i_run ? w_tick : i_step;
    w_frame_next  = r_frame;
    w_wrap_next   = 1'b0;
    if (w_anim_change) begin
      w_frame_next = 5'd0;
    end else if (i_limit == LIMIT_UNSUPPORTED) begin
      w_frame_next = 5'd0;
    end else if (limit_is_degenerate(i_limit)) begin
      w_frame_next = 5'd0;
    end else if (w_advance) begin
      if (r_frame >= (i_limit - 5'd1)) begin
        w_frame_next = 5'd0;
        w_wrap_next  = 1'b1;
      end else begin
        w_frame_next = r_frame + 5'd1;
      end
    end else begin
      w_frame_next = r_frame;
    end
  end

  // Frame state, wrap pulse, validity and the registered animation id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame       <= 5'd0;
      r_frame_valid <= 1'b0;
      r_wrap        <= 1'b0;
      r_anim_q      <= 3'd0;
    end else begin
      r_frame       <= w_frame_next;
      r_frame_valid <= (i_limit != LIMIT_UNSUPPORTED);
      r_wrap        <= w_wrap_next;
      r_anim_q      <= i_animation;
    end
  end

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_wrap        = r_wrap;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Self-checking bench for anim_frame_sequencer with BASE_DIV = 8.
// Each clock, a behavioural model derives the expected frame, wrap and valid
// from elapsed run cycles and the frame rules. The DUT is compared to it on
// every falling edge. Hand-computed literal checks pin key points.
module tb_anim_frame_sequencer;

  localparam int BASE_DIV = 8;
  localparam int DIV_W    = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] animation;
  logic [4:0] limit;
  logic [1:0] speed;
  logic       run;
  logic       step;
  logic [4:0] frame;
  logic       frame_valid;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  anim_frame_sequencer #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_animation   (animation),
    .i_limit       (limit),
    .i_speed       (speed),
    .i_run         (run),
    .i_step        (step),
    .o_frame       (frame),
    .o_frame_valid (frame_valid),
    .o_wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int frame;
    int valid;
    int wrap;
    int anim;
    int elapsed;  // run cycles since the last frame period began
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, int anim, int lim, int spd,
                                         int rn, int stp);
    mstate_t n;
    int      period;
    int      tick;
    int      adv;
    period = BASE_DIV >> spd;
    tick   = (rn != 0 && s.elapsed >= period - 1) ? 1 : 0;
    adv    = (rn != 0) ? tick : stp;
    n       = s;
    n.wrap  = 0;
    n.valid = (lim != 31) ? 1 : 0;
    if (rn != 0) n.elapsed = (tick != 0) ? 0 : s.elapsed + 1;
    if (anim != s.anim) begin
      n.anim    = anim;
      n.frame   = 0;
      n.elapsed = 0;
    end else if (lim == 31 || lim < 2) begin
      n.frame = 0;
    end else if (adv != 0) begin
      if (s.frame + 1 >= lim) begin
        n.frame = 0;
        n.wrap  = 1;
      end else begin
        n.frame = s.frame + 1;
      end
    end
    return n;
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0, 0, 0};
    else m <= model_next(m, int'(animation), int'(limit), int'(speed),
                         int'(run), int'(step));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("model_frame", int'(frame), m.frame);
    check("model_valid", int'(frame_valid), m.valid);
    check("model_wrap", int'(wrap), m.wrap);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    wait_n(1);
    step = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; animation = 3'd0; limit = 5'd10; speed = 2'd0;
    run = 1'b0; step = 1'b0;
    #1 rst_n = 1'b0;
    wait_n(3);
    check("reset_frame", int'(frame), 0);
    check("reset_valid", int'(frame_valid), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    wait_n(1);
    run = 1'b1;

    // Free run at speed 0, limit 10.
    wait_n(7);  check("run_before_first_tick", int'(frame), 0);
    wait_n(1);  check("run_first_tick", int'(frame), 1);
    check("run_valid", int'(frame_valid), 1);
    wait_n(64); check("run_frame9", int'(frame), 9);
    wait_n(8);  check("run_wrap_frame", int'(frame), 0);
    check("run_wrap_pulse", int'(wrap), 1);

    // Speed 2, limit 7: advance every 2 cycles.
    speed = 2'd2; limit = 5'd7;
    wait_n(2);  check("spd2_frame1", int'(frame), 1);
    wait_n(10); check("spd2_frame6", int'(frame), 6);
    wait_n(2);  check("spd2_wrap_frame", int'(frame), 0);
    check("spd2_wrap_pulse", int'(wrap), 1);
    wait_n(1);
    // Count is past the new terminal, so the tick fires on the next edge.
    speed = 2'd3;
    wait_n(1);  check("spd3_frame1", int'(frame), 1);
    wait_n(1);  check("spd3_frame2", int'(frame), 2);
    wait_n(1);  check("spd3_frame3", int'(frame), 3);

    // Pause and single step.
    run = 1'b0; speed = 2'd0;
    wait_n(50); check("pause_hold3", int'(frame), 3);
    step_pulse(); check("step_frame4", int'(frame), 4);
    step_pulse(); check("step_frame5", int'(frame), 5);
    step_pulse(); check("step_frame6", int'(frame), 6);
    step_pulse(); check("step_wrap7", int'(frame), 0);
    check("step_wrap7_pulse", int'(wrap), 1);
    limit = 5'd6;
    for (int i = 0; i < 5; i++) step_pulse();
    check("step_frame5_lim6", int'(frame), 5);
    step_pulse(); check("step_wrap6", int'(frame), 0);
    check("step_wrap6_pulse", int'(wrap), 1);

    // A step while running is ignored.
    run = 1'b1; step = 1'b1;
    wait_n(1);  step = 1'b0;
    check("run_step_ignored", int'(frame), 0);
    wait_n(6);  check("run_step_still0", int'(frame), 0);
    wait_n(1);  check("run_step_tick", int'(frame), 1);

    // Animation change coincident with a tick.
    limit = 5'd10;
    wait_n(32); check("chg_at5", int'(frame), 5);
    wait_n(7);  check("chg_before", int'(frame), 5);
    animation = 3'd4; limit = 5'd6;
    wait_n(1);  check("chg_frame0", int'(frame), 0);
    check("chg_no_wrap", int'(wrap), 0);
    wait_n(7);  check("chg_restart_hold", int'(frame), 0);
    wait_n(1);  check("chg_first_adv", int'(frame), 1);

    // Unsupported animation.
    animation = 3'd6; limit = 5'd31;
    wait_n(1);  check("unsup_valid", int'(frame_valid), 0);
    check("unsup_frame", int'(frame), 0);
    wait_n(20); check("unsup_frame_hold", int'(frame), 0);
    check("unsup_valid_hold", int'(frame_valid), 0);

    // Degenerate limits.
    animation = 3'd2; limit = 5'd1;
    wait_n(1);  check("degen1_valid", int'(frame_valid), 1);
    wait_n(20); check("degen1_frame", int'(frame), 0);
    limit = 5'd0;
    wait_n(10); check("degen0_frame", int'(frame), 0);
    check("degen0_valid", int'(frame_valid), 1);

    // Limit shrinks under a stale frame.
    animation = 3'd0; limit = 5'd10;
    wait_n(1);  check("shrink_start", int'(frame), 0);
    wait_n(64); check("shrink_at8", int'(frame), 8);
    limit = 5'd6;
    wait_n(7);  check("shrink_hold8", int'(frame), 8);
    wait_n(1);  check("shrink_wrap_frame", int'(frame), 0);
    check("shrink_wrap_pulse", int'(wrap), 1);

    // Asynchronous reset between clock edges.
    wait_n(32); check("areset_at4", int'(frame), 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_frame", int'(frame), 0);
    check("areset_valid", int'(frame_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(7);  check("areset_hold", int'(frame), 0);
    wait_n(1);  check("areset_first_adv", int'(frame), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anim_frame_sequencer.md
Name: anim_frame_sequencer

Overview:
- Consumer side of the animation frame-count table: takes the selected animation id and its frame-count limit, and produces the current frame index that drives the 7-segment pattern lookup.
- Sits between the animation-select / frame-limit logic and the segment pattern ROM.
- Contains the tick prescaler, run / pause / single-step control, and wrap and restart handling.

Parameters:
- BASE_DIV, 10_000_000, clock cycles per frame at speed 0 (1 s at 10 MHz). Must be ≥ 8 and a multiple of 8.
- DIV_W, 24, prescaler counter width. Must satisfy BASE_DIV ≤ 2^DIV_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- animation  input  3  selected animation id.
- limit  input  5  frame count for the selected animation. 31 means unsupported id.
- speed  input  2  rate select. Frame period = BASE_DIV >> speed cycles.
- run  input  1  1 = free-running, 0 = paused.
- step  input  1  single-cycle synchronous pulse from the debouncer. Advances one frame while paused.
- frame  output  5  current frame index, registered.
- frame_valid  output  1  1 when the current animation is supported (limit != 31).
- wrap  output  1  one-cycle pulse in the cycle frame returns from limit-1 to 0.

Behaviour:
- Reset (async on rst_n low, release sync to clk):
  - frame = 0, frame_valid = 0, wrap = 0.
  - Prescaler count = 0.
  - anim_q = 0 (registered copy of animation).
- Prescaler:
  - Counts 0 .. (BASE_DIV >> speed) - 1 while run = 1.
  - tick is asserted in the cycle the count is at terminal; the count then returns to 0.
  - run = 0 holds the count.
  - A speed change takes effect immediately. If the count is at or beyond the new terminal, tick fires next cycle and the count returns to 0.
- advance = (run & tick) | (~run & step). A step pulse while run = 1 is ignored.
- Per-cycle priority, highest first:
  1. Animation change (animation != anim_q): frame = 0, prescaler = 0, anim_q = animation, wrap = 0. Any advance in the same cycle is discarded.
  2. Unsupported (limit == 31): frame held at 0, frame_valid = 0, wrap = 0, advance ignored.
  3. Degenerate (limit == 0 or limit == 1): frame held at 0, frame_valid = 1, wrap = 0.
  4. advance, and frame ≥ limit - 1 (covers limit shrinking under a stale frame): frame = 0, wrap = 1.
  5. advance otherwise: frame = frame + 1, wrap = 0.
  6. No advance: hold, wrap = 0.
- frame_valid is registered: (limit != 31), updated every cycle.
- Latency:
  - frame, wrap and frame_valid change exactly 1 cycle after the causing input or tick.
  - First tick after entering run = 1 from a reset prescaler occurs after BASE_DIV >> speed cycles.
- Arithmetic is 5-bit unsigned with no overflow: frame never exceeds 30.
- rst_n asserted mid-frame clears everything immediately, with no wait for clk.

Decomposition:
- Shared package anim_pkg holds:
  - ANIM_W = 3 and FRAME_W = 5.
  - LIMIT_UNSUPPORTED = 5'd31.
  - SPEED_W = 2.
  - The animation id constants ANI0..ANI7.
- One natural sub-module: anim_tick_prescaler (clk, rst_n, run, speed, clear → tick). Its clear input is driven by the animation-change event.
- Frame-control logic stays in the top.

Test Plan (BASE_DIV = 8):
- Reset then run: rst_n low, then high; animation = 0, limit = 10, run = 1, speed = 0 → frame steps 0→1→…→9→0 every 8 cycles. wrap pulses once, in the same cycle frame becomes 0. frame_valid = 1.
- Speed: speed = 2 with limit = 7 → frame advances every 2 cycles. wrap on the 7th advance. Switching to speed = 3 mid-count gives ticks every cycle.
- Pause and step:
  - run = 0 at frame 3 → frame holds 3 for 50 cycles.
  - Three step pulses → frame 4, 5, 6.
  - Steps at limit = 6, frame 5 → frame 0 with wrap = 1.
  - A step while run = 1 causes no extra advance.
- Animation change: at frame 5, animation 0→4 (limit 6) → next cycle frame = 0 and the prescaler restarts. A tick coincident with the change is discarded, so the first advance comes 8 cycles later.
- Unsupported and shrink:
  - animation = 6, limit = 31 → frame_valid = 0, frame = 0, no wrap.
  - Separately, at frame 8 with limit forced 10→6 (no id change) → the next advance gives frame = 0 and wrap = 1.
- Async reset mid-run: rst_n pulsed low between clock edges at frame 4 → frame = 0 and frame_valid = 0 immediately. The first advance comes 8 cycles after release.
